fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the PC and issues one-outstanding requests to instruction memory.
- Buffers returned instructions in a 2-entry FIFO and presents the head to IF/ID as pcIn/instrIn/validInsIn/RsValidIn/RtValidIn/writeRegValidIn.
- Honours IF/ID stall (writeIfId), branch/jump redirect and HALT.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
NOP_INSTR, 16'h0800, instruction word driven when no valid entry

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
writeIfId  in  1  IF/ID captures the head entry this cycle (pop)
redirect  in  1  taken branch/jump resolved downstream
redirectPc  in  16  target PC for redirect
imemReq  out  1  request strobe, one cycle per request
imemAddr  out  16  request address (valid with imemReq)
imemData  in  16  returned instruction (valid with imemDone)
imemDone  in  1  response strobe, at least 1 cycle after imemReq
pcOut  out  16  PC+2 of head instruction (feeds pcIn)
instrOut  out  16  head instruction or NOP_INSTR
validInsOut  out  1  head entry valid
RsValidOut  out  1  head instruction reads Rs
RtValidOut  out  1  head instruction reads Rt
writeRegValidOut  out  1  head instruction writes a register
halted  out  1  fetch stopped after HALT

Behaviour:
- Reset (async): PC=RESET_PC, FIFO empty, no outstanding request, squash=0, halted=0. Outputs: pcOut=0, instrOut=NOP_INSTR, all valids 0, imemReq=0.
- State: FETCH (no outstanding), WAIT (one outstanding), HALTED.
- Pop = writeIfId & FIFO non-empty. Push = imemDone & ~squash & ~redirect.
- Request issue: imemReq=1, imemAddr=PC when (FETCH, or WAIT with imemDone this cycle) & ~redirect & ~halted & ~(HALT pushed this cycle) & (count-pop+push) <= 1; enter or stay in WAIT. Otherwise go to or stay in FETCH on done.
- On push: FIFO stores {instr, PC+2, decode bits}. PC advances by 2 (16-bit wrap; 16'hFFFE -> 16'h0000).
- Throughput: with 1-cycle memory and no stall, 1 instruction per cycle after the first.
- HALT (opcode 00000) pushed: state goes to HALTED, halted=1, no further requests. The HALT entry is still delivered to IF/ID.
- Redirect (highest priority): FIFO flushed same cycle; outputs show bubble the next cycle; PC=redirectPc; halted cleared; state FETCH.
  - If a request is outstanding and imemDone=0, set squash and stay in WAIT. The next imemDone is dropped, squash cleared, state FETCH.
  - If imemDone=1 in the redirect cycle, that data is dropped.
  - First request at redirectPc goes out the cycle after redirect at the earliest.
- Pop and push in the same cycle are legal. Count never exceeds 2; overflow is impossible by the issue rule.
- When the FIFO is empty: validInsOut=0, instrOut=NOP_INSTR, pcOut holds the last value, decode bits 0.
- Decode from opcode=instr[15:11], given as Rs/Rt/wr:
  - HALT, NOP, siic 00010, rti 00011, J 00100: 0/0/0
  - JR 00101, branches 011xx: 1/0/0
  - JAL 00110, LBI 11000: 0/0/1
  - JALR 00111, I-type 010xx/101xx, LD 10001, SLBI 10010, BTR 11001: 1/0/1
  - ST 10000: 1/1/0
  - STU 10011, R-type 11011/11010/111xx: 1/1/1
  - Undefined opcodes: 0/0/0 with validIns=1.

Test Plan:
- Reset, 1-cycle memory returning 0xC001,0x4021,... with writeIfId=1 -> imemAddr 0,2,4 on consecutive cycles; pcOut 2,4,6; LBI gives Rs/Rt/wr=0/0/1.
- Hold writeIfId=0 for 5 cycles -> exactly 2 entries buffered, imemReq low after the second issue. Release -> both delivered in order, no drop, no duplicate.
- Redirect to 0x0100 while a request is outstanding with a 3-cycle done -> late response dropped, validInsOut=0 next cycle, next imemAddr=0x0100.
- Fetch HALT (0x0000) -> halted=1, imemReq stays 0 for 10 cycles, HALT entry reaches IF/ID. Then redirect to 0x0020 -> halted=0, request at 0x0020.
- PC=0xFFFE fetch -> pcOut=0x0000, next imemAddr=0x0000.
- Assert rst mid-WAIT with 2 entries buffered -> outputs immediately at reset values. After release, first request at 0x0000; stale imemDone during reset ignored.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage in front of the IF/ID pipeline register.
// Owns the PC and keeps at most one instruction-memory request in flight.
// Returned words go into a 2-entry FIFO. The FIFO head is held in the output
// registers, so everything IF/ID sees comes straight from flops.
//
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   writeIfId             IF/ID takes the head entry this cycle (pop)
//   redirect, redirectPc  taken branch/jump and its target PC
//   imemReq, imemAddr     request strobe and address (combinational, so a
//                         1-cycle memory can sustain one fetch per cycle)
//   imemData, imemDone    returned instruction word and its strobe
//   pcOut, instrOut       PC+2 of the head instruction, head word or NOP
//   validInsOut           head entry valid
//   RsValidOut, RtValidOut, writeRegValidOut  decode bits of the head
//   halted                fetch stopped after a HALT was accepted
module fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        writeIfId,
    input  logic        redirect,
    input  logic [15:0] redirectPc,
    output logic        imemReq,
    output logic [15:0] imemAddr,
    input  logic [15:0] imemData,
    input  logic        imemDone,
    output logic [15:0] pcOut,
    output logic [15:0] instrOut,
    output logic        validInsOut,
    output logic        RsValidOut,
    output logic        RtValidOut,
    output logic        writeRegValidOut,
    output logic        halted
);

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_WAIT   = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t      state_q;
    logic        squash_q;
    logic [15:0] pc_q;

    // FIFO head: these registers drive the outputs directly
    logic        hv_q;
    logic [15:0] h_instr_q;
    logic [15:0] h_pc_q;
    logic [2:0]  h_dec_q;

    // FIFO second slot
    logic        tv_q;
    logic [15:0] t_instr_q;
    logic [15:0] t_pc_q;
    logic [2:0]  t_dec_q;

    logic        pop_d;
    logic        push_d;
    logic        halt_push_d;
    logic        issue_d;
    logic [15:0] pc_inc_d;
    logic [2:0]  dec_d;
    logic [2:0]  occ_after_d;

    // Returns {reads Rs, reads Rt, writes a register} for an opcode
    function automatic logic [2:0] decode_op(input logic [4:0] op);
        logic [2:0] r;
        casez (op)
            5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100: r = 3'b000;
            5'b00101, 5'b011??:                               r = 3'b100;
            5'b00110, 5'b11000:                               r = 3'b001;
            5'b00111, 5'b010??, 5'b101??,
            5'b10001, 5'b10010, 5'b11001:                     r = 3'b101;
            5'b10000:                                         r = 3'b110;
            5'b10011, 5'b11010, 5'b11011, 5'b111??:           r = 3'b111;
            default:                                          r = 3'b000;
        endcase
        return r;
    endfunction

    // Pop/push qualification and the request-issue decision
    always_comb begin
        pop_d       = writeIfId & hv_q;
        // Only a response to a live (non-squashed) request is accepted; a
        // response arriving with a redirect belongs to the wrong path.
        push_d      = imemDone & (state_q == ST_WAIT) & ~squash_q & ~redirect;
        halt_push_d = push_d & (imemData[15:11] == 5'b00000);
        pc_inc_d    = pc_q + 16'd2;
        dec_d       = decode_op(imemData[15:11]);
        // Occupancy after this cycle; a new request needs a slot reserved for
        // its response, which is what keeps the 2-entry FIFO from overflowing.
        occ_after_d = {2'b00, hv_q} + {2'b00, tv_q} + {2'b00, push_d} - {2'b00, pop_d};
        issue_d     = ~rst & ~redirect & ~halt_push_d & (occ_after_d <= 3'd1) &
                      ((state_q == ST_FETCH) | ((state_q == ST_WAIT) & imemDone));
    end

    assign imemReq          = issue_d;
    // On a push the PC advances this same cycle, so the next fetch goes to PC+2
    assign imemAddr         = push_d ? pc_inc_d : pc_q;
    assign pcOut            = h_pc_q;
    assign instrOut         = h_instr_q;
    assign validInsOut      = hv_q;
    assign RsValidOut       = h_dec_q[2];
    assign RtValidOut       = h_dec_q[1];
    assign writeRegValidOut = h_dec_q[0];
    assign halted           = (state_q == ST_HALTED);

    // Fetch FSM, PC, squash flag and the two FIFO slots
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            squash_q  <= 1'b0;
            pc_q      <= RESET_PC;
            hv_q      <= 1'b0;
            h_instr_q <= NOP_INSTR;
            h_pc_q    <= 16'h0000;
            h_dec_q   <= 3'b000;
            tv_q      <= 1'b0;
            t_instr_q <= NOP_INSTR;
            t_pc_q    <= 16'h0000;
            t_dec_q   <= 3'b000;
        end else if (redirect) begin
            pc_q      <= redirectPc;
            hv_q      <= 1'b0;
            h_instr_q <= NOP_INSTR;
            h_dec_q   <= 3'b000;
            tv_q      <= 1'b0;
            // A request still in flight must have its response thrown away
            if ((state_q == ST_WAIT) && !imemDone) begin
                state_q  <= ST_WAIT;
                squash_q <= 1'b1;
            end else begin
                state_q  <= ST_FETCH;
                squash_q <= 1'b0;
            end
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (issue_d) begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imemDone) begin
                        squash_q <= 1'b0;
                        if (halt_push_d) begin
                            state_q <= ST_HALTED;
                        end else if (issue_d) begin
                            state_q <= ST_WAIT;
                        end else begin
                            state_q <= ST_FETCH;
                        end
                    end
                end
                ST_HALTED: begin
                    state_q <= ST_HALTED;
                end
                default: begin
                    state_q <= ST_FETCH;
                end
            endcase

            if (push_d) begin
                pc_q <= pc_inc_d;
            end

            if (pop_d) begin
                if (tv_q) begin
                    h_instr_q <= t_instr_q;
                    h_pc_q    <= t_pc_q;
                    h_dec_q   <= t_dec_q;
                    tv_q      <= push_d;
                    if (push_d) begin
                        t_instr_q <= imemData;
                        t_pc_q    <= pc_inc_d;
                        t_dec_q   <= dec_d;
                    end
                end else if (push_d) begin
                    h_instr_q <= imemData;
                    h_pc_q    <= pc_inc_d;
                    h_dec_q   <= dec_d;
                end else begin
                    // Empty: show a NOP bubble but keep the last pcOut
                    hv_q      <= 1'b0;
                    h_instr_q <= NOP_INSTR;
                    h_dec_q   <= 3'b000;
                end
            end else if (push_d) begin
                if (!hv_q) begin
                    hv_q      <= 1'b1;
                    h_instr_q <= imemData;
                    h_pc_q    <= pc_inc_d;
                    h_dec_q   <= dec_d;
                end else begin
                    tv_q      <= 1'b1;
                    t_instr_q <= imemData;
                    t_pc_q    <= pc_inc_d;
                    t_dec_q   <= dec_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        writeIfId;
    logic        redirect;
    logic [15:0] redirectPc;
    logic        imemReq;
    logic [15:0] imemAddr;
    logic [15:0] imemData;
    logic        imemDone;
    logic [15:0] pcOut;
    logic [15:0] instrOut;
    logic        validInsOut;
    logic        RsValidOut;
    logic        RtValidOut;
    logic        writeRegValidOut;
    logic        halted;

    fetch_stage #(.RESET_PC(16'h0000), .NOP_INSTR(16'h0800)) dut (
        .clk(clk), .rst(rst), .writeIfId(writeIfId),
        .redirect(redirect), .redirectPc(redirectPc),
        .imemReq(imemReq), .imemAddr(imemAddr),
        .imemData(imemData), .imemDone(imemDone),
        .pcOut(pcOut), .instrOut(instrOut), .validInsOut(validInsOut),
        .RsValidOut(RsValidOut), .RtValidOut(RtValidOut),
        .writeRegValidOut(writeRegValidOut), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
        logic [2:0]  dec;
    } exp_t;

    exp_t        expq[$];
    exp_t        mon_e;
    logic [15:0] mem [logic [15:0]];

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    int          cyc = 0;
    int          epoch = 0;
    logic [15:0] next_addr;
    bit          halted_m, halted_nx;
    bit          pv;
    logic [15:0] pa;
    int          pe, pdue;
    int          req_cnt = 0;

    // stimulus knobs
    int          lat_min = 1, lat_max = 1, wif_pct = 100, rd_pct = 0;
    bit          force_rd = 1'b0;
    logic [15:0] force_tgt = 16'h0000;
    bit          rst_rel = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Rs/Rt/wr from the ISA opcode table
    function automatic logic [2:0] exp_dec(input logic [4:0] op);
        int o;
        o = int'(op);
        if (o == 5 || (o >= 12 && o <= 15)) return 3'b100;
        else if (o == 6 || o == 24) return 3'b001;
        else if (o == 7 || (o >= 8 && o <= 11) || (o >= 20 && o <= 23) ||
                 o == 17 || o == 18 || o == 25) return 3'b101;
        else if (o == 16) return 3'b110;
        else if (o == 19 || o >= 26) return 3'b111;
        else return 3'b000;
    endfunction

    function automatic logic [15:0] get_word(input logic [15:0] a);
        logic [15:0] w;
        if (!mem.exists(a)) begin
            w = 16'($urandom);
            if (w[15:11] == 5'b00000) w[15:11] = 5'b00001;
            mem[a] = w;
        end
        return mem[a];
    endfunction

    task automatic model_init();
        expq.delete();
        epoch++;
        next_addr = 16'h0000;
        pv = 1'b0;
        halted_m = 1'b0;
        halted_nx = 1'b0;
    endtask

    task automatic chk_reset();
        chk("rst_pcOut", pcOut, 16'h0000);
        chk("rst_instrOut", instrOut, 16'h0800);
        chk("rst_flags", {validInsOut, RsValidOut, RtValidOut, writeRegValidOut, halted, imemReq}, 6'b000000);
    endtask

    // One clock cycle: memory side + IF/ID side stimulus, then request checks
    task automatic cycle();
        bit          rd, dn, push_halt, legal;
        logic [15:0] tgt, dat, npc;
        exp_t        e;
        @(posedge clk);
        #1;
        if (rst_rel) begin
            rst = 1'b0;
            rst_rel = 1'b0;
        end
        cyc++;
        rd = force_rd;
        tgt = force_tgt;
        if (!rd && ($urandom_range(0, 99) < rd_pct)) begin
            tgt = 16'($urandom_range(0, 65535)) & 16'hFFFE;
            if ($urandom_range(0, 3) == 0) mem[tgt + 16'd6] = 16'h0000;
            rd = 1'b1;
        end
        dn = 1'b0;
        dat = 16'($urandom);
        push_halt = 1'b0;
        if (pv && cyc >= pdue) begin
            dn = 1'b1;
            dat = get_word(pa);
            pv = 1'b0;
            if (pe == epoch && !rd) begin
                npc = pa + 16'd2;
                e.pc = npc;
                e.instr = dat;
                e.dec = exp_dec(dat[15:11]);
                expq.push_back(e);
                if (dat[15:11] == 5'b00000) begin
                    halted_nx = 1'b1;
                    push_halt = 1'b1;
                end
            end
        end
        if (rd) begin
            epoch++;
            next_addr = tgt;
            halted_nx = 1'b0;
            expq.delete();
        end
        imemDone   = dn;
        imemData   = dat;
        redirect   = rd;
        redirectPc = rd ? tgt : 16'($urandom);
        writeIfId  = rd ? 1'b0 : ($urandom_range(0, 99) < wif_pct);
        @(negedge clk);
        chk("halted", halted, halted_m);
        if (imemReq) begin
            req_cnt++;
            legal = !halted_m && !rd && !push_halt && !pv;
            chk("req_legal", legal, 1'b1);
            chk("req_addr", imemAddr, next_addr);
            pv = 1'b1;
            pa = next_addr;
            pe = epoch;
            pdue = cyc + $urandom_range(lat_min, lat_max);
            next_addr = next_addr + 16'd2;
        end
        halted_m = halted_nx;
    endtask

    task automatic redirect_to(input logic [15:0] t);
        force_rd = 1'b1;
        force_tgt = t;
        cycle();
        force_rd = 1'b0;
    endtask

    // Scoreboard monitor: every IF/ID capture is compared with the queue head
    always @(negedge clk) begin
        if (!rst) begin
            if (validInsOut) begin
                if (writeIfId) begin
                    if (expq.size() == 0) begin
                        chk("pop_expected", 1'b0, 1'b1);
                    end else begin
                        mon_e = expq.pop_front();
                        chk("head_entry",
                            {pcOut, instrOut, RsValidOut, RtValidOut, writeRegValidOut},
                            {mon_e.pc, mon_e.instr, mon_e.dec});
                    end
                end
            end else begin
                chk("bubble", {instrOut, RsValidOut, RtValidOut, writeRegValidOut}, {16'h0800, 3'b000});
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  r0;
        bit  found;
        rst = 1'b1;
        writeIfId = 1'b0;
        redirect = 1'b0;
        redirectPc = 16'h0000;
        imemData = 16'h0000;
        imemDone = 1'b0;
        mem[16'h0000] = 16'hC001;
        mem[16'h0002] = 16'h4021;
        #3;
        chk_reset();
        model_init();
        repeat (2) @(posedge clk);
        rst_rel = 1'b1;

        // streaming with 1-cycle memory: one request every cycle
        r0 = req_cnt;
        repeat (20) cycle();
        chk("throughput_reqs", req_cnt - r0, 20);

        // stall: only two requests fit in the FIFO
        wif_pct = 0;
        redirect_to(16'h0040);
        r0 = req_cnt;
        repeat (5) cycle();
        chk("stall_reqs", req_cnt - r0, 2);
        chk("stall_head_valid", validInsOut, 1'b1);
        wif_pct = 100;
        repeat (6) cycle();

        // redirect with an outstanding 3-cycle request
        lat_min = 3; lat_max = 3; wif_pct = 0;
        redirect_to(16'h0080);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            cycle();
            if (validInsOut && pv && (pdue > cyc + 1)) found = 1'b1;
        end
        chk("redir_setup", found, 1'b1);
        redirect_to(16'h0100);
        cycle();
        chk("redir_bubble", validInsOut, 1'b0);
        wif_pct = 100;
        repeat (12) cycle();

        // HALT stops fetch; redirect restarts it
        lat_min = 1; lat_max = 1;
        mem[16'h0200] = 16'h0000;
        redirect_to(16'h01FC);
        repeat (5) cycle();
        r0 = req_cnt;
        repeat (10) cycle();
        chk("halt_no_reqs", req_cnt - r0, 0);
        chk("halt_flag", halted, 1'b1);
        chk("halt_delivered", expq.size(), 0);
        r0 = req_cnt;
        redirect_to(16'h0020);
        cycle();
        chk("halt_cleared", halted, 1'b0);
        chk("resume_req", req_cnt - r0, 1);
        repeat (5) cycle();

        // PC wrap-around
        redirect_to(16'hFFFC);
        repeat (8) cycle();

        // asynchronous reset with entries buffered
        lat_min = 3; lat_max = 3; wif_pct = 0;
        redirect_to(16'h0300);
        repeat (8) cycle();
        @(posedge clk);
        #2;
        rst = 1'b1;
        imemDone = 1'b1;
        writeIfId = 1'b0;
        redirect = 1'b0;
        #1;
        chk_reset();
        repeat (3) @(posedge clk);
        model_init();
        rst_rel = 1'b1;
        lat_min = 1; lat_max = 1; wif_pct = 100;
        r0 = req_cnt;
        cycle();
        chk("post_reset_req", req_cnt - r0, 1);
        repeat (5) cycle();

        // randomized traffic
        lat_min = 1; lat_max = 3; wif_pct = 70; rd_pct = 3;
        repeat (1500) cycle();

        // drain into a HALT: everything buffered must come out
        rd_pct = 0; lat_min = 1; lat_max = 1; wif_pct = 100;
        mem[16'h3000] = 16'h0000;
        redirect_to(16'h3000);
        repeat (12) cycle();
        chk("drain_empty", expq.size(), 0);
        chk("drain_halted", halted, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
